wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and integer register file for the 5-stage RV32I core. Consumes the MEM/WB pipeline register outputs and selects the writeback result; loads are extracted and sign- or zero-extended here. Commits the result to a 31-entry register file (x0 hardwired to zero) and serves the two combinational decode-stage read ports. Also keeps the 64-bit retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREG, 32, architectural register count (x0 included)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears register file and counter
- ValidW  in  1  writeback stage holds a real (non-bubble) instruction
- RegWriteW  in  1  instruction writes Rd
- ResultSrcW  in  2  00 ALU, 01 load data, 10 PC+4, 11 ALU (reserved)
- LoadCtrlW  in  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- ALUResultW  in  32  ALU result / load effective address
- ReadDataW  in  32  raw aligned data-memory word
- RdW  in  5  destination register
- PCPlus4W  in  32  link value for JAL/JALR
- Rs1D, Rs2D  in  5  decode-stage source register indices
- RD1D, RD2D  out  32  decode-stage read data (combinational)
- ResultW  out  32  selected writeback value (combinational; feeds the forwarding mux)
- InstRetW  out  64  retired-instruction count

## Operation
- Load extraction uses the offset off = ALUResultW[1:0]:
  - LB/LBU: byte at ReadDataW[8*off +: 8], sign- or zero-extended.
  - LH/LHU: half at ReadDataW[16*off[1] +: 16], sign- or zero-extended; off[0] is ignored (no misalign trap).
  - LW and any undefined funct3: the full word.
- ResultW: mux on ResultSrcW; code 11 behaves as 00.
- Write: on the rising edge, if RegWriteW && RdW != 0, regs[RdW] <= ResultW.
  - ValidW is not gated into the write; the pipeline clears RegWriteW on bubbles.
- x0: writes are ignored; reads return 0 regardless of other state.
- Reads: RDnD = regs[RsnD], combinational, no clock.
- Retire counter: increments by 1 on each rising edge with ValidW = 1; wraps from 2^64-1 to 0.

## Timing
- Reset: all registers x1..x31 = 0, InstRetW = 0, asserted immediately (asynchronous). RD1D/RD2D then read 0. ResultW stays combinational from its inputs.
- Reset dominates: an edge with reset high performs no write and no count.
- Write latency: the value is in the array after one rising edge. Without the bypass, a read of the same register in the same cycle returns the old value.
- Simultaneous write and read of the same register: see Configuration.
- Rs1D == Rs2D: both ports return identical data.
- Back-to-back writes to the same Rd: the last edge wins.
- No stall or handshake inputs; the upstream pipeline register holds its values during stalls.
  - A held instruction with ValidW = 1 counts on every held edge, so the pipeline must deassert ValidW while stalled.

## Configuration
- REGFILE_BYPASS_EN defined: internal write-through.
  - When RegWriteW && RdW != 0 && RdW == RsnD, RDnD = ResultW in the same cycle.
  - The hazard unit then needs no WB-to-D forward.
- REGFILE_BYPASS_EN undefined: RDnD always shows the stored value.
  - The new value is visible the cycle after the write edge.
  - The hazard unit must stall or forward for that one cycle.

## Test plan
- Reset release → RD1D = RD2D = 0 for all indices; InstRetW = 0. Then write x5 = 0xDEADBEEF (ResultSrcW = 00) → x5 reads 0xDEADBEEF on the next cycle.
- Loads with ReadDataW = 0x8070F081:
  - LB, off = 0 → 0xFFFFFF81
  - LBU, off = 3 → 0x00000080
  - LH, off = 2 → 0xFFFF8070
  - LHU, off = 0 → 0x0000F081
  - LW → 0x8070F081
- Write RdW = 0 with 0x12345678 → x0 still reads 0. ResultSrcW = 10 with PCPlus4W = 0x104 to x1 → x1 = 0x104.
- Same-cycle write x7 = 0xA5A5A5A5 while Rs1D = 7 (old value 0x11):
  - REGFILE_BYPASS_EN defined → RD1D = 0xA5A5A5A5 in the same cycle.
  - REGFILE_BYPASS_EN undefined → RD1D = 0x11, then 0xA5A5A5A5 after the edge.
- ValidW high for 10 edges with 3 bubbles interleaved → InstRetW = 7. Force the counter to 0xFFFFFFFFFFFFFFFF, then one valid edge → 0.
- Assert reset asynchronously mid-cycle with RegWriteW = 1, RdW = 9 → x9 = 0 and InstRetW = 0 immediately. No write occurs on the following edge while reset is held.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: RV32I writeback stage, integer register file and retire counter.
// Selects the writeback value (ALU / extracted load / PC+4), commits it to
// x1..x31 and serves two combinational decode-stage read ports. x0 reads zero.
// Build option: define REGFILE_BYPASS_EN to make a same-cycle write to RsnD
// visible on RDnD (write-through); otherwise reads show the stored value only.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ValidW,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [2:0]      LoadCtrlW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] ResultW,
  output logic [63:0]     InstRetW
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [63:0]     r_instret;

  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic            w_wen;

  assign w_off = ALUResultW[1:0];
  assign w_wen = RegWriteW && (RdW != 5'd0);

  // Load extraction: pick byte/half by address offset, then extend.
  // Halfword ignores off[0]; misalignment is not trapped here.
  always_comb begin
    w_byte = ReadDataW[{w_off, 3'b000} +: 8];
    w_half = ReadDataW[{w_off[1], 4'b0000} +: 16];
    case (LoadCtrlW)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = ReadDataW;
    endcase
  end

  // Writeback result mux; the reserved code 11 aliases to ALU.
  always_comb begin
    case (ResultSrcW)
      2'b01:   ResultW = w_load;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = ALUResultW;
    endcase
  end

  // Register array commit. Entry 0 is never written, ValidW is not used here
  // because the pipeline already clears RegWriteW on bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wen) begin
      r_regs[RdW] <= ResultW;
    end
  end

  // Decode-stage read ports; x0 forced to zero independent of array contents.
  always_comb begin
    RD1D = (Rs1D == 5'd0) ? '0 : r_regs[Rs1D];
    RD2D = (Rs2D == 5'd0) ? '0 : r_regs[Rs2D];
`ifdef REGFILE_BYPASS_EN
    if (w_wen && (RdW == Rs1D)) RD1D = ResultW;
    if (w_wen && (RdW == Rs2D)) RD2D = ResultW;
`endif
  end

  // Retired-instruction counter; free-running 64-bit wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret <= '0;
    end else if (ValidW) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign InstRetW = r_instret;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of wb_regfile writeback mux, load extraction,
// register writes, x0 behaviour, bypass option, retire counter and async reset.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        ValidW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [2:0]  LoadCtrlW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ResultW;
  logic [63:0] InstRetW;

  int n_checks = 0;
  int n_fail   = 0;

  wb_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .ValidW     (ValidW),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .LoadCtrlW  (LoadCtrlW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .RdW        (RdW),
    .PCPlus4W   (PCPlus4W),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .ResultW    (ResultW),
    .InstRetW   (InstRetW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  ctrl;
    logic [1:0]  off;
    logic [31:0] exp;
    string       tag;
  } load_vec_t;

  load_vec_t lv[7];

  logic [31:0] bypass_exp;
  logic [4:0]  vpat;

  initial begin
    lv[0] = '{3'b000, 2'd0, 32'hFFFF_FF81, "LB_off0"};
    lv[1] = '{3'b100, 2'd3, 32'h0000_0080, "LBU_off3"};
    lv[2] = '{3'b001, 2'd2, 32'hFFFF_8070, "LH_off2"};
    lv[3] = '{3'b101, 2'd0, 32'h0000_F081, "LHU_off0"};
    lv[4] = '{3'b010, 2'd0, 32'h8070_F081, "LW"};
    lv[5] = '{3'b001, 2'd3, 32'hFFFF_8070, "LH_off3_ignores_bit0"};
    lv[6] = '{3'b011, 2'd1, 32'h8070_F081, "undef_funct3_word"};

    reset = 1'b1; ValidW = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00;
    LoadCtrlW = 3'b010; ALUResultW = '0; ReadDataW = '0; RdW = '0;
    PCPlus4W = '0; Rs1D = 5'd3; Rs2D = 5'd4;

    #2;
    chk("reset_instret", InstRetW, 64'd0);
    chk("reset_rd1", {32'd0, RD1D}, 64'd0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Rs1D = 5'(i); Rs2D = 5'(31 - i);
      #1;
      chk($sformatf("reset_rd1_x%0d", i), {32'd0, RD1D}, 64'd0);
      chk($sformatf("reset_rd2_x%0d", 31 - i), {32'd0, RD2D}, 64'd0);
    end
    chk("instret_after_release", InstRetW, 64'd0);

    // Write x5 from ALU, visible next cycle.
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 5'd5; ResultSrcW = 2'b00; ALUResultW = 32'hDEAD_BEEF;
    Rs1D = 5'd5;
    #1 chk("resultw_alu", {32'd0, ResultW}, 64'hDEAD_BEEF);
    tick();
    RegWriteW = 1'b0;
    #1 chk("x5_after_write", {32'd0, RD1D}, 64'hDEAD_BEEF);

    // Load extraction through the result mux.
    ResultSrcW = 2'b01; ReadDataW = 32'h8070_F081;
    foreach (lv[k]) begin
      LoadCtrlW = lv[k].ctrl; ALUResultW = {30'h1000_0000, lv[k].off};
      #1 chk(lv[k].tag, {32'd0, ResultW}, {32'd0, lv[k].exp});
    end
    ResultSrcW = 2'b11; ALUResultW = 32'h0000_0055;
    #1 chk("resultsrc_11_is_alu", {32'd0, ResultW}, 64'h55);

    // x0 write ignored.
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 5'd0; ResultSrcW = 2'b00; ALUResultW = 32'h1234_5678;
    tick();
    RegWriteW = 1'b0; Rs1D = 5'd0; Rs2D = 5'd0;
    #1;
    chk("x0_rd1", {32'd0, RD1D}, 64'd0);
    chk("x0_rd2", {32'd0, RD2D}, 64'd0);

    // PC+4 link write to x1.
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 5'd1; ResultSrcW = 2'b10; PCPlus4W = 32'h0000_0104;
    tick();
    RegWriteW = 1'b0; Rs2D = 5'd1;
    #1 chk("x1_link", {32'd0, RD2D}, 64'h104);

    // Write with ValidW low still commits (RegWriteW alone controls it).
    @(negedge clk);
    ValidW = 1'b0; RegWriteW = 1'b1; RdW = 5'd12; ResultSrcW = 2'b00; ALUResultW = 32'h0BAD_F00D;
    tick();
    RegWriteW = 1'b0; Rs1D = 5'd12;
    #1 chk("x12_write_ungated_by_valid", {32'd0, RD1D}, 64'h0BAD_F00D);

    // Same-cycle write/read of x7.
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 5'd7; ALUResultW = 32'h0000_0011;
    tick();
    RdW = 5'd7; ALUResultW = 32'hA5A5_A5A5; Rs1D = 5'd7; Rs2D = 5'd7;
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'hA5A5_A5A5;
`else
    bypass_exp = 32'h0000_0011;
`endif
    #1;
    chk("x7_same_cycle_rd1", {32'd0, RD1D}, {32'd0, bypass_exp});
    chk("x7_same_cycle_rd2", {32'd0, RD2D}, {32'd0, bypass_exp});
    tick();
    RegWriteW = 1'b0;
    #1;
    chk("x7_after_edge_rd1", {32'd0, RD1D}, 64'hA5A5_A5A5);
    chk("x7_after_edge_rd2", {32'd0, RD2D}, 64'hA5A5_A5A5);

    // Back-to-back writes: last edge wins.
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 5'd3; ALUResultW = 32'h0000_0001;
    tick();
    ALUResultW = 32'h0000_0002;
    tick();
    RegWriteW = 1'b0; Rs1D = 5'd3;
    #1 chk("x3_last_write_wins", {32'd0, RD1D}, 64'h2);

    // Retire counter: 10 edges, bubbles at positions 2, 5, 8.
    chk("instret_before_count", InstRetW, 64'd0);
    for (int e = 0; e < 10; e++) begin
      ValidW = (e % 3) != 2;
      tick();
    end
    ValidW = 1'b0;
    #1 chk("instret_7", InstRetW, 64'd7);
    tick();
    chk("instret_holds_when_invalid", InstRetW, 64'd7);

    // Wrap from all-ones.
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    #1 chk("instret_forced_max", InstRetW, 64'hFFFF_FFFF_FFFF_FFFF);
    ValidW = 1'b1;
    tick();
    ValidW = 1'b0;
    #1 chk("instret_wrap", InstRetW, 64'd0);
    ValidW = 1'b1;
    tick();
    #1 chk("instret_after_wrap", InstRetW, 64'd1);

    // Async reset mid-cycle with a pending write to x9.
    RegWriteW = 1'b1; RdW = 5'd9; ALUResultW = 32'h0000_0099; ValidW = 1'b0;
    tick();
    Rs1D = 5'd9; RegWriteW = 1'b0;
    #1 chk("x9_pre_reset", {32'd0, RD1D}, 64'h99);
    RegWriteW = 1'b1; ALUResultW = 32'h0000_0077; ValidW = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("x9_async_reset", {32'd0, RD1D}, 64'd0);
    chk("instret_async_reset", InstRetW, 64'd0);
    chk("resultw_during_reset", {32'd0, ResultW}, 64'h77);
    tick();
    #1;
    chk("x9_no_write_in_reset", {32'd0, RD1D}, 64'd0);
    chk("instret_no_count_in_reset", InstRetW, 64'd0);
    reset = 1'b0; RegWriteW = 1'b0; ValidW = 1'b0;
    #1 chk("x9_after_release", {32'd0, RD1D}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
